// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg: shared types and helpers for the clock-enable scheduler.
//   DIV_W_DEFAULT : default divisor width
//   ch_idx_t      : channel index wide enough for the 16-channel maximum
//   div_t         : divisor at the default width
//   cfg_req_t     : one configuration request {ch, div}
//   freq_to_div() : divisor that yields a square output of f_out from f_in
package clk_sched_pkg;

  localparam int DIV_W_DEFAULT = 16;
  localparam int CH_IDX_W      = 4;

  typedef logic [CH_IDX_W-1:0]      ch_idx_t;
  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  typedef struct packed {
    ch_idx_t ch;
    div_t    div;
  } cfg_req_t;

  // The square output toggles once per tick, so one output period spans
  // two tick periods: div = f_in / (2 * f_out). Returns 0 (disabled) for f_out = 0.
  function automatic int unsigned freq_to_div(input int unsigned f_in_mhz,
                                              input int unsigned f_out_mhz);
    if (f_out_mhz == 0) return 0;
    return f_in_mhz / (2 * f_out_mhz);
  endfunction

endpackage

// File: rtl/clk_sched_channel.sv
// clk_sched_channel: one scheduler channel. Down-stream consumers see a
// one-cycle tick every div cycles and, when CLK_SCHED_SQUARE_OUT_EN is
// defined, a 50% square wave toggled on each tick (otherwise tied low).
// A written divisor waits in a shadow register and is applied only at the
// period boundary, so the running period always finishes at the old value.
//   clk_in      in   system clock
//   reset       in   synchronous active-high reset
//   i_wr        in   accepted write for this channel (only when not pending)
//   i_div       in   divisor carried by the write (0 disables)
//   o_tick      out  registered one-cycle tick
//   o_clk_out   out  registered square wave (or constant 0)
//   o_pending   out  shadow holds a divisor not yet applied
module clk_sched_channel
  import clk_sched_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic             o_pending
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;

  logic w_disabled;
  logic w_last;

  assign w_disabled = (r_div == '0);
  // Guarded by w_disabled so the div-1 underflow at div=0 never matters.
  assign w_last     = !w_disabled && (r_cnt == (r_div - DIV_W'(1)));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_last;

      if (w_last || w_disabled) r_cnt <= '0;
      else                      r_cnt <= r_cnt + DIV_W'(1);

      // A disabled channel has no period boundary, so it applies at once.
      // i_wr is never asserted while pending, so the branches are exclusive.
      if (r_pending && (w_last || w_disabled)) begin
        r_div     <= r_shadow;
        r_pending <= 1'b0;
      end else if (i_wr) begin
        r_shadow  <= i_div;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef CLK_SCHED_SQUARE_OUT_EN
  logic r_clk_out;

  always_ff @(posedge clk_in) begin
    if (reset)       r_clk_out <= 1'b0;
    else if (w_last) r_clk_out <= ~r_clk_out;
  end

  assign o_clk_out = r_clk_out;
`else
  assign o_clk_out = 1'b0;
`endif

  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_scheduler.sv
// clk_scheduler: N_CH independent clock-enable streams from clk_in, each
// with a runtime-programmable divisor written through a valid/ready port.
// Divisor changes take effect at the channel's period boundary.
// Optional feature macro: CLK_SCHED_SQUARE_OUT_EN (square clk_out outputs;
// when undefined clk_out is all zeros).
//   clk_in     in   system clock (CLK_IN_F_MHZ nominal)
//   reset      in   synchronous active-high reset
//   cfg_valid  in   configuration write request
//   cfg_ready  out  write accepted when high with cfg_valid (combinational)
//   cfg_ch     in   target channel; out-of-range writes are accepted and dropped
//   cfg_div    in   new divisor, 0 disables the channel
//   tick       out  per-channel one-cycle enable pulse
//   clk_out    out  per-channel square wave toggled on each tick
//   pending    out  per-channel accepted divisor not yet applied
module clk_scheduler
  import clk_sched_pkg::*;
#(
  parameter int CLK_IN_F_MHZ = 100,
  parameter int N_CH         = 4,
  parameter int DIV_W        = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV  = 2,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  pending
);

  if (N_CH < 1 || N_CH > 16 || CLK_IN_F_MHZ < 1) begin : g_bad_param
    $error("clk_scheduler: N_CH must be 1..16 and CLK_IN_F_MHZ positive");
  end

  logic [N_CH-1:0] w_sel;
  logic [N_CH-1:0] w_wr;
  logic [N_CH-1:0] w_pending;

  // One-hot decode; an index >= N_CH selects nothing, which makes it
  // read as ready and lets the write fall on the floor.
  assign cfg_ready = ~|(w_sel & w_pending);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_sel[i] = (cfg_ch == CH_W'(i));
    assign w_wr[i]  = cfg_valid & w_sel[i] & ~w_pending[i];

    clk_sched_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in    (clk_in),
      .reset     (reset),
      .i_wr      (w_wr[i]),
      .i_div     (cfg_div),
      .o_tick    (tick[i]),
      .o_clk_out (clk_out[i]),
      .o_pending (w_pending[i])
    );
  end

  assign pending = w_pending;

endmodule

// File: tb/tb_clk_scheduler.sv
// Directed bench for clk_scheduler: a table of per-edge vectors for the
// divisor-change / stall sequence, then hand-written sequences for
// disable/re-enable, div=1, reset with a pending write and out-of-range writes.
module tb_clk_scheduler;

`ifdef CLK_SCHED_SQUARE_OUT_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch  = '0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  tick, clk_out, pending;

  // Three-channel instance so index 3 is representable but out of range.
  logic        cfg_valid3 = 1'b0;
  logic        cfg_ready3;
  logic [1:0]  cfg_ch3  = '0;
  logic [15:0] cfg_div3 = '0;
  logic [2:0]  tick3, clk_out3, pending3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  clk_scheduler #(.N_CH(4), .DIV_W(16), .DEFAULT_DIV(2)) u_dut (
    .clk_in(clk_in), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .clk_out(clk_out),
    .pending(pending)
  );

  clk_scheduler #(.N_CH(3), .DIV_W(16), .DEFAULT_DIV(2)) u_dut3 (
    .clk_in(clk_in), .reset(reset), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .tick(tick3), .clk_out(clk_out3),
    .pending(pending3)
  );

  typedef struct {
    logic        vld;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        rdy;
    logic [3:0]  tk;
    logic [3:0]  ck;
    logic [3:0]  pd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_valid3 = 1'b0;
    cfg_ch     = 2'd0;
    edge1();
    edge1();
    chk("rst_tick",    32'(tick),      32'h0);
    chk("rst_pending", 32'(pending),   32'h0);
    chk("rst_clk_out", 32'(clk_out),   32'h0);
    chk("rst_ready",   32'(cfg_ready), 32'h1);
    chk("rst_tick3",   32'(tick3),     32'h0);
    reset = 1'b0;
  endtask

  initial begin
    // edge | ch1 event
    //  1   | accept div=5 (ch1 at cnt 0 of div 2)
    //  2   | tick, apply 5
    //  3   | accept div=3
    // 4..7 | div=4 offered but stalled; 7 = tick + apply 3
    //  8   | div=4 accepted
    //  10  | tick + apply 4; next tick at 14
    vecs[0]  = '{1'b1, 2'd1, 16'd5, 1'b1, 4'b0000, 4'b0000, 4'b0010};
    vecs[1]  = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b1111, 4'b1111, 4'b0000};
    vecs[2]  = '{1'b1, 2'd1, 16'd3, 1'b1, 4'b0000, 4'b1111, 4'b0010};
    vecs[3]  = '{1'b1, 2'd1, 16'd4, 1'b0, 4'b1101, 4'b0010, 4'b0010};
    vecs[4]  = '{1'b1, 2'd1, 16'd4, 1'b0, 4'b0000, 4'b0010, 4'b0010};
    vecs[5]  = '{1'b1, 2'd1, 16'd4, 1'b0, 4'b1101, 4'b1111, 4'b0010};
    vecs[6]  = '{1'b1, 2'd1, 16'd4, 1'b0, 4'b0010, 4'b1101, 4'b0000};
    vecs[7]  = '{1'b1, 2'd1, 16'd4, 1'b1, 4'b1101, 4'b0000, 4'b0010};
    vecs[8]  = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b0000, 4'b0000, 4'b0010};
    vecs[9]  = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b1111, 4'b1111, 4'b0000};
    vecs[10] = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b0000, 4'b1111, 4'b0000};
    vecs[11] = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b1101, 4'b0010, 4'b0000};
    vecs[12] = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b0000, 4'b0010, 4'b0000};
    vecs[13] = '{1'b0, 2'd0, 16'd0, 1'b1, 4'b1111, 4'b1101, 4'b0000};

    // ---- table: divisor change, stalled second write ----
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cfg_valid = vecs[i].vld;
      cfg_ch    = vecs[i].ch;
      cfg_div   = vecs[i].div;
      #1;
      chk($sformatf("v%0d_ready", i + 1), 32'(cfg_ready), 32'(vecs[i].rdy));
      edge1();
      chk($sformatf("v%0d_tick", i + 1),    32'(tick),    32'(vecs[i].tk));
      chk($sformatf("v%0d_clk_out", i + 1), 32'(clk_out), SQ ? 32'(vecs[i].ck) : 32'h0);
      chk($sformatf("v%0d_pending", i + 1), 32'(pending), 32'(vecs[i].pd));
    end
    cfg_valid = 1'b0;

    // ---- ch2: disable, then re-enable at div=3 ----
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
    #1;
    chk("dis_ready", 32'(cfg_ready), 32'h1);
    edge1();
    cfg_valid = 1'b0;
    chk("dis_pend1", 32'(pending[2]), 32'h1);
    edge1();
    chk("dis_last_tick", 32'(tick[2]),    32'h1);
    chk("dis_pend2",     32'(pending[2]), 32'h0);
    for (int n = 3; n <= 8; n++) begin
      edge1();
      chk($sformatf("dis_e%0d_tick", n), 32'(tick[2]),    32'h0);
      chk($sformatf("dis_e%0d_clk", n),  32'(clk_out[2]), 32'(SQ));
    end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd3;
    #1;
    chk("ren_ready", 32'(cfg_ready), 32'h1);
    edge1();                                   // edge 9: accept
    cfg_valid = 1'b0;
    chk("ren_pend_on", 32'(pending[2]), 32'h1);
    edge1();                                   // edge 10: apply
    chk("ren_pend_off", 32'(pending[2]), 32'h0);
    chk("ren_e10_tick", 32'(tick[2]),    32'h0);
    for (int n = 11; n <= 12; n++) begin
      edge1();
      chk($sformatf("ren_e%0d_tick", n), 32'(tick[2]), 32'h0);
    end
    edge1();                                   // edge 13: first tick
    chk("ren_first_tick", 32'(tick[2]),    32'h1);
    chk("ren_first_clk",  32'(clk_out[2]), 32'h0);

    // ---- ch0: div=1 ----
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1;
    edge1();
    cfg_valid = 1'b0;
    edge1();
    chk("d1_e2_tick", 32'(tick[0]),    32'h1);
    chk("d1_e2_clk",  32'(clk_out[0]), 32'(SQ));
    for (int n = 3; n <= 8; n++) begin
      edge1();
      chk($sformatf("d1_e%0d_tick", n), 32'(tick[0]),    32'h1);
      chk($sformatf("d1_e%0d_clk", n),  32'(clk_out[0]), 32'(SQ && (n % 2 == 0)));
    end

    // ---- reset with ch3 pending div=7 ----
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
    edge1();
    cfg_valid = 1'b0;
    #1;
    chk("rp_pend_set",   32'(pending), 32'h8);
    chk("rp_ready_low",  32'(cfg_ready), 32'h0);
    reset = 1'b1;
    edge1();
    chk("rp_pend_clr",   32'(pending), 32'h0);
    chk("rp_tick_clr",   32'(tick),    32'h0);
    reset = 1'b0;
    #1;
    chk("rp_ready_back", 32'(cfg_ready), 32'h1);
    // out-of-range write on the 3-channel instance at the same time
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 16'd5;
    #1;
    chk("oor_ready", 32'(cfg_ready3), 32'h1);
    edge1();                                   // edge 1
    cfg_valid3 = 1'b0;
    chk("oor_pending", 32'(pending3), 32'h0);
    chk("rp_e1_tick",  32'(tick),     32'h0);
    edge1();                                   // edge 2
    chk("rp_e2_tick",  32'(tick),     32'hf);
    chk("oor_e2_tick", 32'(tick3),    32'h7);
    edge1();
    chk("rp_e3_tick",  32'(tick),     32'h0);
    edge1();
    chk("rp_e4_tick",  32'(tick),     32'hf);
    chk("rp_e4_pend",  32'(pending),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_scheduler.md
# clk_scheduler

Multi-channel clock-enable scheduler that derives N_CH independent tick streams (and optional divided square clocks) from `clk_in`, with each channel's divisor programmable at runtime through a valid/ready configuration port. It sits between the board clock and the slow-rate consumers (display multiplexing, debouncers, blinkers) and replaces per-consumer fixed dividers with one configurable resource. Divisor changes are glitch-free: a new value takes effect only at the channel's period boundary.

## Interface
- `CLK_IN_F_MHZ`, 100, input clock frequency; documentation and the package helper only.
- `N_CH`, 4, number of channels (1..16).
- `DIV_W`, 16, divisor width.
- `DEFAULT_DIV`, 2, divisor loaded into every channel at reset.
- `clk_in`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset, sampled on `clk_in`.
- `cfg_valid`  in  1  configuration write request.
- `cfg_ready`  out  1  write accepted this cycle when high together with `cfg_valid`.
- `cfg_ch`  in  $clog2(N_CH) (min 1)  target channel.
- `cfg_div`  in  DIV_W  new divisor; 0 disables the channel.
- `tick`  out  N_CH  one-cycle enable pulse per channel period.
- `clk_out`  out  N_CH  square wave toggled on each tick (see Configuration).
- `pending`  out  N_CH  channel has an accepted divisor not yet applied.

## Operation
- Per channel registers: `cnt` (DIV_W), `div` (active), `shadow` (DIV_W), `pending`, `tick`, `clk_out`.
- Reset: `cnt`=0, `div`=DEFAULT_DIV, `shadow`=0, `pending`=0, `tick`=0, `clk_out`=0. `cfg_ready` reads 1 after reset.
- Counting (div ≥ 1): at each edge, if `cnt` == div−1 then `cnt`←0, `tick`←1, `clk_out`←~`clk_out`; else `cnt`←`cnt`+1, `tick`←0.
- div = 1: `tick` high every cycle, `clk_out` toggles every cycle (f_in/2).
- div = 0: channel disabled; `cnt` held 0, `tick`=0, `clk_out` holds its value.
- `cfg_ready` = ~`pending[cfg_ch]` (combinational); 1 when `cfg_ch` ≥ N_CH, in which case the write is accepted and discarded.
- On handshake: `shadow[cfg_ch]`←`cfg_div`, `pending[cfg_ch]`←1.
- Apply: at the edge where a pending channel hits terminal count (same edge that fires its tick), `div`←`shadow`, `cnt`←0, `pending`←0. The current period always completes at the old divisor; the next period uses the new one.
- Disabled channel with pending: apply on the next edge after acceptance; counting starts from 0.
- Write to a pending channel is stalled (`cfg_ready`=0) until apply; no overwriting of `shadow`.
- Writing the same divisor is legal and still sets/clears `pending` normally.
- Reset mid-period or with pending writes: all pending writes discarded, all channels return to DEFAULT_DIV.

## Timing
- `tick`, `clk_out`, `pending` are registered outputs; `cfg_ready` is combinational from `cfg_ch` and `pending`.
- First tick after reset release: high in the cycle following edge DEFAULT_DIV (edges counted from the first edge with `reset`=0).
- Tick period = div cycles; `clk_out` period = 2·div cycles, 50% duty.
- `pending` rises the cycle after handshake and falls the cycle after the apply edge.
- Max latency handshake→apply: old div cycles.

## Configuration
- `CLK_SCHED_SQUARE_OUT_EN` defined: `clk_out` toggle flops implemented as described.
- Not defined: `clk_out` tied to all-zeros; toggle flops omitted; `tick` behaviour unchanged.

## Structure
- Package `clk_sched_pkg`: `DIV_W` default, `ch_idx_t`, `div_t`, a `cfg_req_t` struct {ch, div}, and function `freq_to_div(f_in_mhz, f_out_mhz)` returning f_in/(2·f_out) for square-output sizing.
- Sub-module `clk_sched_channel`: one channel (counter, active/shadow divisor, pending, tick, clk_out), instantiated N_CH times by a generate loop; top handles decode and `cfg_ready`.

## Test plan
- Reset, no writes, DEFAULT_DIV=2 -> each `tick` high every 2nd cycle, first after edge 2; `clk_out` period 4 cycles.
- Write ch1 div=5 while ch1 at cnt=0 of div=2 -> one more 2-cycle period, then ticks every 5 cycles; `pending[1]` high exactly until apply; other channels unaffected.
- Second write to ch1 while pending -> `cfg_ready`=0 until apply, then accepted.
- Write ch2 div=0, then div=3 -> ch2 silent with `clk_out` frozen; after re-enable first tick 3 cycles after apply.
- Write div=1 to ch0 -> `tick[0]` continuously high, `clk_out[0]` toggles every cycle.
- Reset asserted with ch3 pending div=7 -> `pending`=0, ch3 resumes DEFAULT_DIV; write to `cfg_ch`=N_CH (N_CH<2^width) accepted with no effect.
